// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes the IF/ID instruction, bypasses write-back data into the
// operands, stalls on load-use hazards and registers the result into ID/EX under valid/ready.
module decode_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [31:0]           if_pc,
  output logic                  id_ready,
  output logic [REG_ADDR_W-1:0] rf_rs1,
  output logic [REG_ADDR_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  id_valid,
  output logic [31:0]           id_pc,
  output logic [XLEN-1:0]       id_op_a,
  output logic [XLEN-1:0]       id_op_b,
  output logic [31:0]           id_imm,
  output logic [REG_ADDR_W-1:0] id_rd,
  output logic [6:0]            id_opcode,
  output logic [2:0]            id_funct3,
  output logic                  id_funct7b5,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rd_field;
  logic [REG_ADDR_W-1:0] rd_next;
  logic [31:0]           imm_next;
  logic                  use_rs1;
  logic                  use_rs2;
  logic                  illegal_next;
  logic                  reg_write_next;
  logic                  mem_read_next;
  logic                  mem_write_next;
  logic                  hazard;
  logic                  advance;
  logic                  accept;

  assign opcode   = if_instr[6:0];
  assign rd_field = if_instr[11:7];
  assign rf_rs1   = if_instr[19:15];
  assign rf_rs2   = if_instr[24:20];

  always_comb begin
    imm_next       = '0;
    rd_next        = rd_field;
    use_rs1        = 1'b1;
    use_rs2        = 1'b0;
    illegal_next   = 1'b0;
    reg_write_next = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm_next       = {if_instr[31:12], 12'b0};
        use_rs1        = 1'b0;
        reg_write_next = 1'b1;
      end
      OPC_JAL: begin
        imm_next       = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                          if_instr[30:21], 1'b0};
        use_rs1        = 1'b0;
        reg_write_next = 1'b1;
      end
      OPC_JALR, OPC_OPIMM: begin
        imm_next       = {{20{if_instr[31]}}, if_instr[31:20]};
        reg_write_next = 1'b1;
      end
      OPC_LOAD: begin
        imm_next       = {{20{if_instr[31]}}, if_instr[31:20]};
        reg_write_next = 1'b1;
        mem_read_next  = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: imm_next = {{20{if_instr[31]}}, if_instr[31:20]};
      OPC_STORE: begin
        imm_next       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        rd_next        = '0;
        use_rs2        = 1'b1;
        mem_write_next = 1'b1;
      end
      OPC_BRANCH: begin
        imm_next = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
        rd_next  = '0;
        use_rs2  = 1'b1;
      end
      OPC_OP: begin
        use_rs2        = 1'b1;
        reg_write_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so never advertise them downstream.
    if (rd_field == '0) reg_write_next = 1'b0;
  end

  // Two read ports share the same bypass rule; x0 is forced to zero independently of the RF.
  logic [REG_ADDR_W-1:0] rs_addr [2];
  logic [XLEN-1:0]       rs_data [2];
  logic [XLEN-1:0]       op_next [2];

  assign rs_addr[0] = rf_rs1;
  assign rs_addr[1] = rf_rs2;
  assign rs_data[0] = rf_rs1_data;
  assign rs_data[1] = rf_rs2_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      always_comb begin
        op_next[gi] = rs_data[gi];
        if (rs_addr[gi] == '0)
          op_next[gi] = '0;
        else if (wb_we && (wb_rd == rs_addr[gi]))
          op_next[gi] = wb_data;
      end
    end
  endgenerate

  assign hazard = if_valid && id_valid && id_mem_read && (id_rd != '0) &&
                  ((use_rs1 && (rf_rs1 == id_rd)) || (use_rs2 && (rf_rs2 == id_rd)));
  assign advance  = ex_ready || !id_valid;
  assign id_ready = advance && !hazard && !flush && rst_n;
  assign accept   = if_valid && id_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_op_a      <= '0;
      id_op_b      <= '0;
      id_imm       <= '0;
      id_rd        <= '0;
      id_opcode    <= '0;
      id_funct3    <= '0;
      id_funct7b5  <= 1'b0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (accept) begin
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_op_a      <= op_next[0];
      id_op_b      <= op_next[1];
      id_imm       <= imm_next;
      id_rd        <= rd_next;
      id_opcode    <= opcode;
      id_funct3    <= if_instr[14:12];
      id_funct7b5  <= if_instr[30];
      id_reg_write <= reg_write_next;
      id_mem_read  <= mem_read_next;
      id_mem_write <= mem_write_next;
      id_illegal   <= illegal_next;
    end else if (flush || advance) begin
      // Flush, hazard bubble or plain drain: only the side-effect flags must be cleared.
      id_valid     <= 1'b0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a per-cycle reference model of the issue rules plus
// literal expectations for the key instructions.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc, id_op_a, id_op_b, id_imm;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_write, id_mem_read, id_mem_write, id_illegal;

  logic [31:0] rf [32];
  int errors = 0;
  int checks = 0;
  bit started = 0;

  always #5 clk = ~clk;

  assign rf_rs1_data = rf[rf_rs1];
  assign rf_rs2_data = rf[rf_rs2];

  decode_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_op_a(id_op_a), .id_op_b(id_op_b),
    .id_imm(id_imm), .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_illegal(id_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5, rw, mr, mw, ill, zeroed;
  } model_t;
  model_t m;

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic signed [31:0] s;
    s = $signed(i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 32'(s >>> 20);
      7'h23: return (32'(s >>> 20) & ~32'h1F) | {27'b0, i[11:7]};
      7'h63: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf[rs];
  endfunction

  function automatic bit m_ready();
    logic [6:0] o;
    bit u1, u2, hz;
    o  = if_instr[6:0];
    u1 = !(o inside {7'h37, 7'h17, 7'h6F});
    u2 = o inside {7'h33, 7'h23, 7'h63};
    hz = if_valid && m.valid && m.mr && m.rd != 5'd0 &&
         ((u1 && if_instr[19:15] == m.rd) || (u2 && if_instr[24:20] == m.rd));
    return rst_n && (!m.valid || ex_ready) && !hz && !flush;
  endfunction

  always @(posedge clk) begin
    logic [6:0] o;
    bit rdy;
    rdy = m_ready();
    started = 1;
    o = if_instr[6:0];
    if (!rst_n) begin
      m = '0;
      m.zeroed = 1'b1;
    end else if (flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    end else if (if_valid && rdy) begin
      m.valid  = 1;
      m.zeroed = 0;
      m.pc     = if_pc;
      m.a      = m_operand(if_instr[19:15]);
      m.b      = m_operand(if_instr[24:20]);
      m.imm    = m_imm(if_instr);
      m.rd     = (o inside {7'h23, 7'h63}) ? 5'd0 : if_instr[11:7];
      m.opc    = o;
      m.f3     = if_instr[14:12];
      m.f7b5   = if_instr[30];
      m.ill    = !is_legal(o);
      m.rw     = (if_instr[11:7] != 0) && (o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33});
      m.mr     = (o == 7'h03);
      m.mw     = (o == 7'h23);
    end else if (ex_ready || !m.valid) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("id_valid", 32'(id_valid), 32'(m.valid));
      check("id_reg_write", 32'(id_reg_write), 32'(m.rw));
      check("id_mem_read", 32'(id_mem_read), 32'(m.mr));
      check("id_mem_write", 32'(id_mem_write), 32'(m.mw));
      check("id_ready", 32'(id_ready), 32'(m_ready()));
      check("rf_rs1", 32'(rf_rs1), 32'(if_instr[19:15]));
      check("rf_rs2", 32'(rf_rs2), 32'(if_instr[24:20]));
      if (m.valid || m.zeroed) begin
        check("id_pc", id_pc, m.pc);
        check("id_op_a", id_op_a, m.a);
        check("id_op_b", id_op_b, m.b);
        check("id_imm", id_imm, m.imm);
        check("id_rd", 32'(id_rd), 32'(m.rd));
        check("id_opcode", 32'(id_opcode), 32'(m.opc));
        check("id_funct3", 32'(id_funct3), 32'(m.f3));
        check("id_funct7b5", 32'(id_funct7b5), 32'(m.f7b5));
        check("id_illegal", 32'(id_illegal), 32'(m.ill));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  localparam logic [31:0] I_ADDI5  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_LW     = 32'h0000A303; // lw x6,0(x1)
  localparam logic [31:0] I_ADD    = 32'h002303B3; // add x7,x6,x2
  localparam logic [31:0] I_ADDI8  = 32'h00018413; // addi x8,x3,0
  localparam logic [31:0] I_ADDI9  = 32'h00500493; // addi x9,x0,5
  localparam logic [31:0] I_SW     = 32'h0020A223; // sw x2,4(x1)
  localparam logic [31:0] I_BEQ    = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] I_LUI    = 32'h12345537; // lui x10,0x12345
  localparam logic [31:0] I_JAL    = 32'h010000EF; // jal x1,+16
  localparam logic [31:0] I_ILL    = 32'hFFFFFFFF;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h0000_0100;
    rf[2] = 32'h0000_0022;
    rf[6] = 32'h0000_0066;
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    offer(I_ADDI5, 32'h0);
    tick(); tick();
    check("rst id_valid", 32'(id_valid), 32'd0);
    check("rst id_imm", id_imm, 32'h0);
    check("rst id_pc", id_pc, 32'h0);
    check("rst id_ready", 32'(id_ready), 32'd0);
    rst_n = 1'b1; if_valid = 1'b0;
    #2 check("post-rst id_ready", 32'(id_ready), 32'd1);

    offer(I_ADDI5, 32'h100); tick();
    check("addi valid", 32'(id_valid), 32'd1);
    check("addi imm", id_imm, 32'hFFFF_FFFF);
    check("addi rd", 32'(id_rd), 32'd5);
    check("addi reg_write", 32'(id_reg_write), 32'd1);
    check("addi op_a", id_op_a, 32'h0);

    offer(I_LW, 32'h104); tick();
    check("lw mem_read", 32'(id_mem_read), 32'd1);
    offer(I_ADD, 32'h108);
    #2 check("lu id_ready", 32'(id_ready), 32'd0);
    tick();
    check("lu bubble", 32'(id_valid), 32'd0);
    check("lu ready again", 32'(id_ready), 32'd1);
    tick();
    check("add valid", 32'(id_valid), 32'd1);
    check("add rd", 32'(id_rd), 32'd7);
    check("add op_b", id_op_b, 32'h22);

    offer(I_ADDI8, 32'h10C); wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF; tick();
    check("bypass op_a", id_op_a, 32'hDEAD_BEEF);
    offer(I_ADDI8, 32'h110); wb_rd = 5'd0; tick();
    check("wb x0 op_a", id_op_a, 32'h0);
    offer(I_ADDI9, 32'h114); tick();
    check("rs x0 op_a", id_op_a, 32'h0);
    wb_we = 1'b0;

    offer(I_SW, 32'h118); tick();
    check("sw imm", id_imm, 32'h4);
    check("sw rd", 32'(id_rd), 32'd0);
    offer(I_BEQ, 32'h11C); ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2 check("stall id_ready", 32'(id_ready), 32'd0);
      tick();
      check("stall id_pc", id_pc, 32'h118);
    end
    ex_ready = 1'b1; tick();
    check("beq pc", id_pc, 32'h11C);
    check("beq imm", id_imm, 32'hFFFF_FFF8);

    offer(I_LUI, 32'h120); tick();
    check("lui imm", id_imm, 32'h1234_5000);
    offer(I_JAL, 32'h124); tick();
    check("jal imm", id_imm, 32'h10);
    offer(I_ILL, 32'h128); tick();
    check("ill flag", 32'(id_illegal), 32'd1);
    check("ill valid", 32'(id_valid), 32'd1);
    check("ill reg_write", 32'(id_reg_write), 32'd0);

    offer(I_ADDI5, 32'h12C); flush = 1'b1;
    #2 check("flush id_ready", 32'(id_ready), 32'd0);
    tick();
    check("flush valid", 32'(id_valid), 32'd0);
    flush = 1'b0; if_valid = 1'b0; tick();
    check("drained valid", 32'(id_valid), 32'd0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
